// File: rtl/hdmi_tx.sv
// DVI/HDMI video transmitter: CEA-861 raster counters, 2-stage pipeline, TMDS 8b/10b encoding.
// Emits three parallel 10-bit channel words plus the TMDS clock pattern; serialisation is external.
module hdmi_tx #(
  parameter int VIDEO_ID_CODE = 4,
  parameter int START_X       = 0,
  parameter int START_Y       = 0
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  input  logic [23:0] rgb,
  output logic [10:0] cx,
  output logic [9:0]  cy,
  output logic [10:0] frame_width,
  output logic [9:0]  frame_height,
  output logic [29:0] tmds,
  output logic [9:0]  tmds_clock
);

  localparam bit Vic1 = (VIDEO_ID_CODE == 1);

  localparam logic [10:0] HAct       = Vic1 ? 11'd640 : 11'd1280;
  localparam logic [10:0] HSyncStart = Vic1 ? 11'd656 : 11'd1390;
  localparam logic [10:0] HSyncEnd   = Vic1 ? 11'd752 : 11'd1430;
  localparam logic [10:0] FrameW     = Vic1 ? 11'd800 : 11'd1650;
  localparam logic [9:0]  VAct       = Vic1 ? 10'd480 : 10'd720;
  localparam logic [9:0]  VSyncStart = Vic1 ? 10'd490 : 10'd725;
  localparam logic [9:0]  VSyncEnd   = Vic1 ? 10'd492 : 10'd730;
  localparam logic [9:0]  FrameH     = Vic1 ? 10'd525 : 10'd750;
  // Negative-polarity modes drive the sync lines low while asserted.
  localparam logic        SyncNeg    = Vic1 ? 1'b1 : 1'b0;

  localparam logic [10:0] StartX   = 11'(START_X);
  localparam logic [9:0]  StartY   = 10'(START_Y);
  localparam logic [9:0]  CtrlIdle = 10'b1101010100;

  if (VIDEO_ID_CODE != 1 && VIDEO_ID_CODE != 4) begin : g_bad_vic
    $error("hdmi_tx: unsupported VIDEO_ID_CODE");
  end

  assign frame_width  = FrameW;
  assign frame_height = FrameH;
  assign tmds_clock   = 10'b0000011111;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] code;
    unique case (c)
      2'b00:   code = 10'b1101010100;
      2'b01:   code = 10'b0010101011;
      2'b10:   code = 10'b0101010100;
      default: code = 10'b1010101011;
    endcase
    return code;
  endfunction

  // Returns {next disparity, 10-bit word} for one active-video byte.
  function automatic logic [14:0] tmds_encode(input logic [7:0] d, input logic signed [4:0] cnt);
    logic [3:0]        n1d;
    logic              use_xnor;
    logic [8:0]        qm;
    logic [3:0]        n1q;
    logic [3:0]        n0q;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_n;
    logic [9:0]        word;
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d = n1d + {3'b000, d[i]};
    end
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1q = n1q + {3'b000, qm[i]};
    end
    n0q  = 4'd8 - n1q;
    diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
    if ((cnt == 5'sd0) || (n1q == n0q)) begin
      word  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (n1q > n0q)) || ((cnt < 5'sd0) && (n0q > n1q))) begin
      word  = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      word  = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
    end
    return {cnt_n, word};
  endfunction

  logic [10:0]       cx_d;
  logic [9:0]        cy_d;
  logic              de_c;
  logic              hsync_c;
  logic              vsync_c;
  logic              de_q;
  logic              hsync_q;
  logic              vsync_q;
  logic [23:0]       rgb_q;
  logic [29:0]       tmds_d;
  logic signed [4:0] cnt_q  [3];
  logic signed [4:0] cnt_d  [3];
  logic signed [4:0] cnt_nx [3];
  logic [9:0]        word_nx [3];

  always_comb begin
    cx_d = cx + 11'd1;
    cy_d = cy;
    if (cx == FrameW - 11'd1) begin
      cx_d = 11'd0;
      cy_d = (cy == FrameH - 10'd1) ? 10'd0 : cy + 10'd1;
    end
  end

  always_comb begin
    de_c    = (cx < HAct) && (cy < VAct);
    hsync_c = ((cx >= HSyncStart) && (cx < HSyncEnd)) ^ SyncNeg;
    vsync_c = ((cy >= VSyncStart) && (cy < VSyncEnd)) ^ SyncNeg;
  end

  // Channel order: ch0 = blue, ch1 = green, ch2 = red; only ch0 carries sync in blanking.
  always_comb begin
    tmds_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      {cnt_nx[ch], word_nx[ch]} = tmds_encode(rgb_q[ch*8 +: 8], cnt_q[ch]);
      if (de_q) begin
        tmds_d[ch*10 +: 10] = word_nx[ch];
        cnt_d[ch]           = cnt_nx[ch];
      end else begin
        tmds_d[ch*10 +: 10] = ctrl_code((ch == 0) ? {vsync_q, hsync_q} : 2'b00);
        cnt_d[ch]           = 5'sd0;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      cx      <= StartX;
      cy      <= StartY;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      rgb_q   <= '0;
      tmds    <= {3{CtrlIdle}};
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= 5'sd0;
      end
    end else begin
      cx      <= cx_d;
      cy      <= cy_d;
      de_q    <= de_c;
      hsync_q <= hsync_c;
      vsync_q <= vsync_c;
      rgb_q   <= rgb;
      tmds    <= tmds_d;
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_hdmi_tx.sv
// Scoreboard bench for hdmi_tx (VIC4): random pixels, reference raster and TMDS model,
// decoupled monitor comparing cx/cy and tmds against queued expectations.
module tb_hdmi_tx;

  localparam int StartX = 1000;
  localparam int StartY = 716;
  localparam int W      = 1650;
  localparam int H      = 750;

  logic        clk = 1'b0;
  logic        resetn;
  logic [23:0] rgb;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] frame_width;
  logic [9:0]  frame_height;
  logic [29:0] tmds;
  logic [9:0]  tmds_clock;

  always #5 clk = ~clk;

  hdmi_tx #(
    .VIDEO_ID_CODE(4),
    .START_X      (StartX),
    .START_Y      (StartY)
  ) dut (
    .clk_pixel   (clk),
    .resetn      (resetn),
    .rgb         (rgb),
    .cx          (cx),
    .cy          (cy),
    .frame_width (frame_width),
    .frame_height(frame_height),
    .tmds        (tmds),
    .tmds_clock  (tmds_clock)
  );

  typedef struct {
    int unsigned due;
    logic [29:0] val;
    int          pix;
  } exp_t;

  exp_t pos_q[$];
  exp_t word_q[$];

  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  int unsigned edges = 0;
  int          checks = 0;
  int          errors = 0;
  int          mcnt [3];

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Reference TMDS encoder written straight from the DVI rules, disparity kept as 5-bit signed.
  function automatic void enc(input logic [7:0] d, input int cin, output logic [9:0] w,
                              output int cout);
    int         ones;
    bit         use_xnor;
    logic [8:0] qm;
    int         n1;
    int         n0;
    int         c;
    ones     = $countones(d);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      c = qm[8] ? cin + n1 - n0 : cin + n0 - n1;
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      c = cin + 2 * int'(qm[8]) + n0 - n1;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      c = cin - 2 * int'(!qm[8]) + n1 - n0;
    end
    c = c & 31;
    if (c >= 16) c = c - 32;
    cout = c;
  endfunction

  // Monitor: pops each expectation on the falling edge where it falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (pos_q.size() > 0 && pos_q[0].due <= edges) begin
        e = pos_q.pop_front();
        if (e.due != edges) begin
          check($sformatf("pos_late@%0d", e.pix), 64'(edges), 64'(e.due));
        end else begin
          check($sformatf("cx@%0d", e.pix), 64'(cx), 64'(e.val[10:0]));
          check($sformatf("cy@%0d", e.pix), 64'(cy), 64'(e.val[20:11]));
        end
      end
      while (word_q.size() > 0 && word_q[0].due <= edges) begin
        e = word_q.pop_front();
        if (e.due != edges) check($sformatf("tmds_late@%0d", e.pix), 64'(edges), 64'(e.due));
        else check($sformatf("tmds@%0d", e.pix), 64'(tmds), 64'(e.val));
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_cx", 64'(cx), 64'(StartX));
    check("rst_cy", 64'(cy), 64'(StartY));
    check("rst_tmds", 64'(tmds), 64'({3{10'b1101010100}}));
    check("frame_width", 64'(frame_width), 64'd1650);
    check("frame_height", 64'(frame_height), 64'd750);
    check("tmds_clock", 64'(tmds_clock), 64'h1F);
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
  endtask

  task automatic run(input int npix);
    int          p;
    int          x;
    int          y;
    bit          de;
    bit          hs;
    bit          vs;
    logic [9:0]  ch [3];
    logic [29:0] pos;
    int          nc;
    resetn = 1'b1;
    word_q.push_back('{edges, {3{10'b1101010100}}, -1});
    word_q.push_back('{edges + 1, {3{10'b1101010100}}, -1});
    for (int n = 0; n < npix; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      p = StartX + StartY * W + n;
      x = p % W;
      y = (p / W) % H;
      if ((y == 717 || y == 0) && x < 3) rgb = 24'h000000;
      else if ((y == 718 || y == 1) && x == 0) rgb = 24'hFFFFFF;
      else rgb = 24'($urandom());
      pos = '0;
      pos[10:0]  = x[10:0];
      pos[20:11] = y[9:0];
      pos_q.push_back('{edges, pos, n});
      de = (x < 1280) && (y < 720);
      hs = (x >= 1390) && (x < 1430);
      vs = (y >= 725) && (y < 730);
      for (int c = 0; c < 3; c++) begin
        if (de) begin
          enc(rgb[8*c +: 8], mcnt[c], ch[c], nc);
          mcnt[c] = nc;
        end else begin
          ch[c]   = (c == 0) ? ctrl_tab[{vs, hs}] : ctrl_tab[0];
          mcnt[c] = 0;
        end
      end
      word_q.push_back('{edges + 2, {ch[2], ch[1], ch[0]}, n});
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("pos_drain", 64'(pos_q.size()), 64'd0);
    check("tmds_drain", 64'(word_q.size()), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    rgb    = '0;
    do_reset();
    // Through the vsync lines, across the frame wrap, ending mid-line inside active video.
    run(57250);
    do_reset();
    run(4000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
